clk_wiz_drp_ctrl: RTL and testbench
===================================

Name: clk_wiz_drp_ctrl

Overview:
- Runtime reconfiguration controller for the system clock wizard (MMCM) through its DRP port.
- Accepts a batch of register read-modify-write entries from a host over valid/ready.
- Sequences the batch: hold MMCM in reset → RMW each register → release reset → wait for lock. Reports done or error.
- Runs on the free-running external clock (never on a wizard output) and sits beside the sys_clock wrapper in the shell.

Parameters:
- DRP_TIMEOUT, 1024: max ext_clk cycles from den to drdy before declaring a DRP error.
- LOCK_TIMEOUT, 1048576: max ext_clk cycles from mmcm_rst release to synchronized lock.
- SYNC_STAGES, 2: flop stages on the async mmcm_locked input (≥2).

Ports:
- ext_clk  in  1  controller and DRP clock
- rst  in  1  asynchronous, active-high reset
- cfg_valid  in  1  host entry valid
- cfg_ready  out  1  controller can accept an entry
- cfg_addr  in  7  DRP register address
- cfg_data  in  16  new field bits
- cfg_mask  in  16  1 = keep existing bit, 0 = take cfg_data bit
- cfg_last  in  1  final entry of batch
- drp_daddr  out  7  DRP address
- drp_den  out  1  DRP enable, one-cycle pulse
- drp_dwe  out  1  DRP write enable, only with den
- drp_di  out  16  DRP write data
- drp_do  in  16  DRP read data
- drp_drdy  in  1  DRP access complete
- mmcm_locked  in  1  wizard locked, asynchronous
- mmcm_rst  out  1  wizard reset
- busy  out  1  batch in progress
- done  out  1  one-cycle pulse at batch end (success or error)
- err  out  1  sticky error flag
- err_code  out  2  0 none, 1 DRP read timeout, 2 DRP write timeout, 3 lock timeout

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, counters 0.
  - mmcm_rst = 0 in reset so the wizard free-runs.
  - Reset mid-batch abandons the batch immediately.
- Entry acceptance:
  - cfg_ready = 1 only in IDLE and NEXT.
  - An entry is accepted on cfg_valid & cfg_ready and latched into entry registers.
- States:
  - IDLE: on accept, set mmcm_rst = 1, busy = 1, clear err/err_code, go to RD.
  - RD: one cycle of den = 1, dwe = 0, daddr = entry addr. Clear timer, go to RD_W.
  - RD_W: on drdy, capture new = (drp_do & mask) | (data & ~mask), go to WR. Otherwise timer++. When timer == DRP_TIMEOUT-1 without drdy, go to ERR with code 1.
  - WR: one cycle of den = 1, dwe = 1, di = new. Clear timer, go to WR_W.
  - WR_W: on drdy, if last: set mmcm_rst = 0, clear timer, go to LOCK_W; else go to NEXT. Timeout as in RD_W, code 2.
  - NEXT: mmcm_rst stays 1 and there is no timeout (host paces the batch). On accept, go to RD.
  - LOCK_W: ignore the synchronized lock during the first cycle after release. Go to DONE when the synchronized lock is 1. Timeout at LOCK_TIMEOUT-1, code 3.
  - DONE: done = 1 for one cycle, busy = 0, go to IDLE.
  - ERR: mmcm_rst = 0, err = 1, set err_code, done = 1 for one cycle, busy = 0, go to IDLE.
- Boundary rules:
  - drdy arriving in the same cycle the timer reaches its limit counts as success.
  - drdy outside RD_W/WR_W is ignored.
  - cfg_valid held without ready is not consumed.
  - After an error the host must restart the batch from its first entry.
  - drp_daddr and drp_di hold their last values when den = 0; drp_dwe = 0 whenever den = 0.
- Latency per entry, zero-wait DRP (drdy the cycle after den): accept → RD 1, RD_W 1, WR 1, WR_W 1 = 4 cycles until the next cfg_ready.
- Timer width is $clog2(LOCK_TIMEOUT)+1 and is shared by all waits.

Optional Feature:
- Macro: CLK_DRP_READBACK_EN.
- Defined:
  - After WR_W, add states VR (den = 1, dwe = 0) and VR_W.
  - If drp_do != new, go to ERR with code 2 (write error). Readback timeout is also code 2.
  - Per-entry latency becomes 6 cycles.
- Undefined: no verify states; WR_W transitions directly as above.

Decomposition:
- Package clk_drp_pkg:
  - state enum
  - err_code localparams (ERR_NONE, ERR_RD_TO, ERR_WR_TO, ERR_LOCK_TO)
  - DRP_AW = 7 and DRP_DW = 16
- Sub-module sync_bit: SYNC_STAGES-deep synchronizer for mmcm_locked, reset to 0 by rst.

Test Plan:
- Single entry: addr 0x08, data 0x1041, mask 0xF000, DRP returns 0xA3C3 → write di 0xA041, mmcm_rst high throughout, lock asserted 10 cycles after release → done pulse, err = 0.
- Three-entry batch with 5-cycle gaps in cfg_valid → cfg_ready only in NEXT, mmcm_rst stays 1 across the gaps, exactly 3 reads and 3 writes in address order.
- drdy withheld on the read → ERR after DRP_TIMEOUT cycles, err_code = 1, mmcm_rst = 0, done pulse; a new batch afterwards clears err.
- Lock never asserts → err_code = 3 exactly LOCK_TIMEOUT cycles after release; drdy on the timeout boundary cycle → success path.
- rst asserted in WR_W → all outputs 0 the next edge, FSM in IDLE, cfg_ready = 1 after release.
- With CLK_DRP_READBACK_EN, readback differs from di → err_code = 2; matching readback → 6-cycle entry latency.

Source files
------------

// File: rtl/clk_drp_pkg.sv
// Shared types and constants for the clock-wizard DRP reconfiguration controller.
package clk_drp_pkg;

  localparam int DRP_AW = 7;
  localparam int DRP_DW = 16;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_RD_TO   = 2'd1;
  localparam logic [1:0] ERR_WR_TO   = 2'd2;
  localparam logic [1:0] ERR_LOCK_TO = 2'd3;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD,
    ST_RD_W,
    ST_WR,
    ST_WR_W,
    ST_VR,
    ST_VR_W,
    ST_NEXT,
    ST_LOCK_W,
    ST_DONE,
    ST_ERR
  } state_t;

  // Read-modify-write merge: mask bit 1 keeps the register bit, 0 takes the new bit.
  function automatic logic [DRP_DW-1:0] rmw_merge(input logic [DRP_DW-1:0] old_val,
                                                  input logic [DRP_DW-1:0] new_bits,
                                                  input logic [DRP_DW-1:0] keep_mask);
    return (old_val & keep_mask) | (new_bits & ~keep_mask);
  endfunction

  // States during which the wizard must be held in reset.
  function automatic logic holds_mmcm(input state_t s);
    return (s == ST_RD) || (s == ST_RD_W) || (s == ST_WR) || (s == ST_WR_W) ||
           (s == ST_VR) || (s == ST_VR_W) || (s == ST_NEXT);
  endfunction

endpackage

// File: rtl/clk_wiz_drp_ctrl_sync_bit.sv
// Multi-flop synchronizer for a single asynchronous level (used for mmcm_locked).
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  // Shift the async level through STAGES flops; cleared on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/clk_wiz_drp_ctrl.sv
// DRP reconfiguration sequencer for the system clock wizard.
// Holds the MMCM in reset, read-modify-writes each host entry over DRP,
// releases reset and waits for lock. Runs on the free-running ext_clk.
// Optional macro CLK_DRP_READBACK_EN adds a verify read after every write.
module clk_wiz_drp_ctrl
  import clk_drp_pkg::*;
#(
  parameter int DRP_TIMEOUT  = 1024,
  parameter int LOCK_TIMEOUT = 1048576,
  parameter int SYNC_STAGES  = 2
) (
  input  logic              ext_clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [DRP_AW-1:0] cfg_addr,
  input  logic [DRP_DW-1:0] cfg_data,
  input  logic [DRP_DW-1:0] cfg_mask,
  input  logic              cfg_last,
  output logic [DRP_AW-1:0] drp_daddr,
  output logic              drp_den,
  output logic              drp_dwe,
  output logic [DRP_DW-1:0] drp_di,
  input  logic [DRP_DW-1:0] drp_do,
  input  logic              drp_drdy,
  input  logic              mmcm_locked,
  output logic              mmcm_rst,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);

  // One timer serves every wait, so it is sized for the longest one.
  localparam int TIMER_SPAN = (LOCK_TIMEOUT > DRP_TIMEOUT) ? LOCK_TIMEOUT : DRP_TIMEOUT;
  localparam int TW = $clog2(TIMER_SPAN) + 1;
  localparam logic [TW-1:0] DRP_LIM  = TW'(DRP_TIMEOUT - 1);
  localparam logic [TW-1:0] LOCK_LIM = TW'(LOCK_TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [1:0]        code_d;
  logic              run_q;
  logic              locked_s;
  logic              accept;
  logic [DRP_AW-1:0] ent_addr_q;
  logic [DRP_DW-1:0] ent_data_q;
  logic [DRP_DW-1:0] ent_mask_q;
  logic              ent_last_q;
  logic [DRP_DW-1:0] new_q;
  logic              mmcm_rst_q;
  logic              err_q;
  logic [1:0]        err_code_q;

  sync_bit #(
    .STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk(ext_clk),
    .rst(rst),
    .d  (mmcm_locked),
    .q  (locked_s)
  );

  // run_q keeps cfg_ready low while reset is asserted and for the first edge after.
  assign cfg_ready = run_q && ((state_q == ST_IDLE) || (state_q == ST_NEXT));
  assign accept    = cfg_valid && cfg_ready;

  assign drp_den   = (state_q == ST_RD) || (state_q == ST_WR) || (state_q == ST_VR);
  assign drp_dwe   = (state_q == ST_WR);
  assign drp_daddr = ent_addr_q;
  assign drp_di    = new_q;
  assign busy      = (state_q != ST_IDLE) && (state_q != ST_DONE) && (state_q != ST_ERR);
  assign done      = (state_q == ST_DONE) || (state_q == ST_ERR);
  assign mmcm_rst  = mmcm_rst_q;
  assign err       = err_q;
  assign err_code  = err_code_q;

  // State, shared timer and ready-enable register.
  always_ff @(posedge ext_clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      run_q   <= 1'b1;
    end
  end

  // Next-state, timer and error-code selection.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    code_d  = err_code_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_RD;
      end
      ST_RD: begin
        timer_d = '0;
        state_d = ST_RD_W;
      end
      ST_RD_W: begin
        if (drp_drdy) begin
          state_d = ST_WR;
        end else if (timer_q == DRP_LIM) begin
          state_d = ST_ERR;
          code_d  = ERR_RD_TO;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_WR: begin
        timer_d = '0;
        state_d = ST_WR_W;
      end
      ST_WR_W: begin
        if (drp_drdy) begin
`ifdef CLK_DRP_READBACK_EN
          state_d = ST_VR;
`else
          if (ent_last_q) begin
            state_d = ST_LOCK_W;
            timer_d = '0;
          end else begin
            state_d = ST_NEXT;
          end
`endif
        end else if (timer_q == DRP_LIM) begin
          state_d = ST_ERR;
          code_d  = ERR_WR_TO;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
`ifdef CLK_DRP_READBACK_EN
      ST_VR: begin
        timer_d = '0;
        state_d = ST_VR_W;
      end
      ST_VR_W: begin
        if (drp_drdy) begin
          if (drp_do != new_q) begin
            state_d = ST_ERR;
            code_d  = ERR_WR_TO;
          end else if (ent_last_q) begin
            state_d = ST_LOCK_W;
            timer_d = '0;
          end else begin
            state_d = ST_NEXT;
          end
        end else if (timer_q == DRP_LIM) begin
          state_d = ST_ERR;
          code_d  = ERR_WR_TO;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
`endif
      ST_NEXT: begin
        if (accept) state_d = ST_RD;
      end
      ST_LOCK_W: begin
        // The synchronizer may still show the pre-release level on the first cycle.
        if ((timer_q != '0) && locked_s) begin
          state_d = ST_DONE;
        end else if (timer_q == LOCK_LIM) begin
          state_d = ST_ERR;
          code_d  = ERR_LOCK_TO;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered wizard reset and sticky error status, aligned with the state they follow.
  always_ff @(posedge ext_clk or posedge rst) begin
    if (rst) begin
      mmcm_rst_q <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      mmcm_rst_q <= holds_mmcm(state_d);
      if (state_d == ST_ERR) begin
        err_q      <= 1'b1;
        err_code_q <= code_d;
      end else if ((state_q == ST_IDLE) && accept) begin
        err_q      <= 1'b0;
        err_code_q <= ERR_NONE;
      end
    end
  end

  // DRP address and write data; both hold their value between accesses.
  always_ff @(posedge ext_clk or posedge rst) begin
    if (rst) begin
      ent_addr_q <= '0;
      new_q      <= '0;
    end else begin
      if (accept) ent_addr_q <= cfg_addr;
      if ((state_q == ST_RD_W) && drp_drdy) new_q <= rmw_merge(drp_do, ent_data_q, ent_mask_q);
    end
  end

  // Entry payload latched on acceptance; only consumed after an accept.
  always_ff @(posedge ext_clk) begin
    if (accept) begin
      ent_data_q <= cfg_data;
      ent_mask_q <= cfg_mask;
      ent_last_q <= cfg_last;
    end
  end

endmodule

// File: tb/tb_clk_wiz_drp_ctrl.sv
// Self-checking bench for clk_wiz_drp_ctrl with a behavioural DRP register file
// and MMCM lock model. Honours CLK_DRP_READBACK_EN when defined.
module tb_clk_wiz_drp_ctrl;

  localparam int DRP_TO  = 16;
  localparam int LOCK_TO = 64;
`ifdef CLK_DRP_READBACK_EN
  localparam int ENT_LAT = 6;
`else
  localparam int ENT_LAT = 4;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [6:0]  cfg_addr = '0;
  logic [15:0] cfg_data = '0;
  logic [15:0] cfg_mask = '0;
  logic        cfg_last = 1'b0;
  logic [6:0]  drp_daddr;
  logic        drp_den;
  logic        drp_dwe;
  logic [15:0] drp_di;
  logic [15:0] drp_do = '0;
  logic        drp_drdy = 1'b0;
  logic        mmcm_locked = 1'b0;
  logic        mmcm_rst;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;

  always #5 clk = ~clk;

  clk_wiz_drp_ctrl #(
    .DRP_TIMEOUT (DRP_TO),
    .LOCK_TIMEOUT(LOCK_TO),
    .SYNC_STAGES (2)
  ) dut (
    .ext_clk    (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .cfg_mask   (cfg_mask),
    .cfg_last   (cfg_last),
    .drp_daddr  (drp_daddr),
    .drp_den    (drp_den),
    .drp_dwe    (drp_dwe),
    .drp_di     (drp_di),
    .drp_do     (drp_do),
    .drp_drdy   (drp_drdy),
    .mmcm_locked(mmcm_locked),
    .mmcm_rst   (mmcm_rst),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .err_code   (err_code)
  );

  int tests = 0;
  int fails = 0;

  // DRP register file model: answers each den after drp_delay wait cycles.
  logic [15:0] mem [128];
  logic [7:0]  log_q [$];
  int          drp_delay = 0;
  bit          hold_rd = 0, hold_wr = 0, corrupt_vr = 0;
  bit          pend = 0, last_was_wr = 0;
  int          cnt = 0;
  logic [15:0] rd_val = '0;
  bit          rst_viol = 0, rdy_viol = 0, dwe_viol = 0;

  always @(negedge clk) begin
    drp_drdy = 1'b0;
    if (rst) pend = 0;
    if (pend) begin
      if (cnt == 0) begin
        drp_drdy = 1'b1;
        drp_do   = rd_val;
        pend     = 0;
      end else begin
        cnt--;
      end
    end
    if (!drp_den && drp_dwe) dwe_viol = 1;
    if (drp_den) begin
      log_q.push_back({drp_dwe, drp_daddr});
      if (!mmcm_rst) rst_viol = 1;
      if (cfg_ready) rdy_viol = 1;
      if (drp_dwe) begin
        mem[drp_daddr] = drp_di;
        rd_val = drp_di;
        last_was_wr = 1;
      end else begin
        rd_val = mem[drp_daddr];
        if (corrupt_vr && last_was_wr) rd_val = ~rd_val;
        last_was_wr = 0;
      end
      if (!(drp_dwe ? hold_wr : hold_rd)) begin
        pend = 1;
        cnt  = drp_delay;
      end
    end
  end

  // MMCM lock model: low while held in reset, high lock_dly cycles after release.
  int since_rel = 1000;
  bit lock_en = 1;
  int lock_dly = 10;

  always @(negedge clk) begin
    if (mmcm_rst) begin
      since_rel   = 0;
      mmcm_locked = 1'b0;
    end else begin
      if (since_rel < 100000) since_rel++;
      mmcm_locked = lock_en && (since_rel >= lock_dly);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one entry and hold it until accepted (bounded).
  task automatic send(input logic [6:0] a, input logic [15:0] d, input logic [15:0] m,
                      input logic l, output bit ok);
    cfg_addr = a; cfg_data = d; cfg_mask = m; cfg_last = l; cfg_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      if (cfg_ready) begin
        ok = 1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    cfg_valid = 1'b0;
  endtask

  task automatic wait_done(input int maxc, output int n);
    n = 0;
    while (!done && n < maxc) begin
      @(negedge clk);
      n++;
    end
    if (!done) n = -1;
  endtask

  logic [6:0]  b_addr [8];
  logic [15:0] b_data [8];
  logic [15:0] b_mask [8];
  int          b_n;

  // Run the batch in b_* and check the DRP traffic and final register contents.
  task automatic do_batch(input string tag, input int gap);
    logic [15:0] exp_mem [128];
    logic [7:0]  exp_log [$];
    bit ok, gap_viol;
    int k, n, bad;
    for (int i = 0; i < 128; i++) exp_mem[i] = mem[i];
    for (int i = 0; i < b_n; i++) begin
      exp_mem[b_addr[i]] = (exp_mem[b_addr[i]] & b_mask[i]) | (b_data[i] & ~b_mask[i]);
      exp_log.push_back({1'b0, b_addr[i]});
      exp_log.push_back({1'b1, b_addr[i]});
`ifdef CLK_DRP_READBACK_EN
      exp_log.push_back({1'b0, b_addr[i]});
`endif
    end
    log_q.delete();
    rst_viol = 0; rdy_viol = 0; dwe_viol = 0; gap_viol = 0;
    for (int i = 0; i < b_n; i++) begin
      send(b_addr[i], b_data[i], b_mask[i], i == b_n - 1, ok);
      chk({tag, "_accept"}, 32'(ok), 1);
      if (i == 0) chk({tag, "_err_clr"}, 32'(err), 0);
      if (i < b_n - 1 && gap > 0) begin
        k = 0;
        while (!cfg_ready && k < 100) begin
          @(negedge clk);
          k++;
        end
        if (drp_delay == 0) chk({tag, "_entry_lat"}, 32'(k), 32'(ENT_LAT));
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          if (!mmcm_rst || !cfg_ready) gap_viol = 1;
        end
      end
    end
    wait_done(3000, n);
    chk({tag, "_done_seen"}, 32'(n >= 0), 1);
    chk({tag, "_status"}, {28'd0, err, err_code, busy}, 0);
    chk({tag, "_rst_released"}, 32'(mmcm_rst), 0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done), 0);
    chk({tag, "_n_access"}, 32'(log_q.size()), 32'(exp_log.size()));
    bad = 0;
    for (int i = 0; i < exp_log.size() && i < log_q.size(); i++)
      if (log_q[i] !== exp_log[i]) bad++;
    chk({tag, "_access_order"}, 32'(bad), 0);
    bad = 0;
    for (int i = 0; i < 128; i++) if (mem[i] !== exp_mem[i]) bad++;
    chk({tag, "_regs"}, 32'(bad), 0);
    chk({tag, "_protocol"}, {28'd0, rst_viol, rdy_viol, dwe_viol, gap_viol}, 0);
  endtask

  initial begin
    bit ok;
    int n, k;
    for (int i = 0; i < 128; i++) mem[i] = 16'($urandom);

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_outputs", {cfg_ready, drp_den, drp_dwe, drp_daddr, drp_di, mmcm_rst,
                          busy, done, err, err_code}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("ready_after_reset", 32'(cfg_ready), 1);

    // Single entry with the documented values
    mem[8] = 16'hA3C3;
    b_n = 1; b_addr[0] = 7'h08; b_data[0] = 16'h1041; b_mask[0] = 16'hF000;
    lock_dly = 10;
    do_batch("single", 1);
    chk("single_value", 32'(mem[8]), 32'h0000A041);

    // Three entries paced by the host with 5-cycle gaps
    b_n = 3;
    for (int i = 0; i < 3; i++) begin
      b_addr[i] = 7'(7'h10 + i); b_data[i] = 16'($urandom); b_mask[i] = 16'($urandom);
    end
    do_batch("three_gap", 5);

    // Read never answered: read timeout
    hold_rd = 1;
    send(7'h20, 16'h1234, 16'h00FF, 1'b1, ok);
    wait_done(DRP_TO + 20, n);
    chk("rd_to_latency", 32'(n), 32'(DRP_TO + 1));
    chk("rd_to_status", {28'd0, err, err_code, mmcm_rst}, {28'd0, 1'b1, 2'd1, 1'b0});
    @(negedge clk);
    chk("rd_to_done_pulse", {30'd0, done, err}, {30'd0, 1'b0, 1'b1});
    hold_rd = 0;

    // Write never answered: write timeout
    hold_wr = 1;
    send(7'h21, 16'h5678, 16'h0F0F, 1'b1, ok);
    wait_done(3 * DRP_TO, n);
    chk("wr_to_status", {29'd0, err, err_code}, {29'd0, 1'b1, 2'd2});
    hold_wr = 0;
    @(negedge clk);

    // Fresh batch after an error clears err; drdy exactly on the timeout boundary
    drp_delay = DRP_TO - 1;
    b_n = 1; b_addr[0] = 7'h22; b_data[0] = 16'hBEEF; b_mask[0] = 16'h00F0;
    do_batch("boundary_drdy", 1);
    drp_delay = DRP_TO;
    send(7'h23, 16'h0001, 16'h0000, 1'b1, ok);
    wait_done(6 * DRP_TO, n);
    chk("past_boundary", {29'd0, err, err_code}, {29'd0, 1'b1, 2'd1});
    drp_delay = 0;
    @(negedge clk);

    // Lock never returns: lock timeout measured from release
    lock_en = 0;
    send(7'h24, 16'h00AA, 16'hFF00, 1'b1, ok);
    k = 0;
    while (mmcm_rst && k < 100) begin
      @(negedge clk);
      k++;
    end
    k = 0;
    while (!err && k < LOCK_TO + 20) begin
      @(negedge clk);
      k++;
    end
    chk("lock_to_latency", 32'(k), 32'(LOCK_TO));
    chk("lock_to_status", {29'd0, done, err_code}, {29'd0, 1'b1, 2'd3});
    lock_en = 1;
    repeat (2) @(negedge clk);

    // Reset asserted while waiting for the write to complete
    drp_delay = 8;
    send(7'h25, 16'hC0DE, 16'h0000, 1'b1, ok);
    k = 0;
    while (!drp_dwe && k < 50) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midbatch_reset", {cfg_ready, drp_den, drp_dwe, drp_daddr, drp_di, mmcm_rst,
                           busy, done, err, err_code}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("ready_after_midreset", {30'd0, cfg_ready, busy}, {30'd0, 1'b1, 1'b0});
    drp_delay = 0;

`ifdef CLK_DRP_READBACK_EN
    // Verify read returns something other than what was written
    corrupt_vr = 1;
    send(7'h26, 16'h1111, 16'h0000, 1'b1, ok);
    wait_done(200, n);
    chk("readback_mismatch", {29'd0, err, err_code}, {29'd0, 1'b1, 2'd2});
    corrupt_vr = 0;
    @(negedge clk);
`endif

    // Randomized batches, including repeated addresses and early-held cfg_valid
    for (int r = 0; r < 6; r++) begin
      b_n = $urandom_range(1, 4);
      for (int i = 0; i < b_n; i++) begin
        b_addr[i] = (r % 2 == 0) ? 7'($urandom_range(0, 3)) : 7'($urandom);
        b_data[i] = 16'($urandom);
        b_mask[i] = 16'($urandom);
      end
      drp_delay = $urandom_range(0, 3);
      lock_dly  = $urandom_range(1, 20);
      do_batch($sformatf("rand%0d", r), $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
